// File: rtl/cdec_dp_gen_if.sv
// Memory bus between the CDEC data path (master) and external memory (slave).
interface cdec_dp_gen_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] adrs;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          mem_req;
  logic          mem_we;
  logic          mem_ack;

  modport master (
    output adrs, data_out, mem_req, mem_we,
    input  data_in, mem_ack
  );

  modport slave (
    input  adrs, data_out, mem_req, mem_we,
    output data_in, mem_ack
  );
endinterface

// File: rtl/cdec_dp_gen.sv
// CDEC data path: register file, XBUS, ALU, synchronised input port,
// debug read mux and a handshaked memory-cycle FSM with timeout.
//   state   | meaning
//   ST_IDLE | no memory cycle, control strobes accepted
//   ST_CYC  | mem_req held, waiting for mem_ack or timeout; controls ignored
module cdec_dp_gen #(
  parameter int            DW      = 8,
  parameter int            NREG    = 3,
  parameter logic [DW-1:0] PC_RST  = '0,
  parameter int            TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset_N,
  input  logic [DW-1:0]       io_in,
  output logic [DW-1:0]       io_out,
  cdec_dp_gen_if.master       mem,
  input  logic [4:0]          xsrc,
  input  logic [4:0]          xdst,
  input  logic [3:0]          aluop,
  input  logic                rwr,
  input  logic                fwr,
  input  logic                pc_inc,
  input  logic                mem_rd,
  input  logic                mem_wr,
  output logic [DW-1:0]       I,
  output logic [2:0]          SZCy,
  output logic                busy,
  output logic                bus_err,
  input  logic [7:0]          resad,
  output logic [DW-1:0]       resdt
);
  typedef enum logic {ST_IDLE, ST_CYC} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d, i_q, i_d, t_q, t_d, r_q, r_d;
  logic [DW-1:0] mar_q, mar_d, wdr_q, wdr_d, rdr_q, rdr_d, flg_q, flg_d;
  logic [DW-1:0] oport_q, oport_d, sync1_q, sync2_q;
  logic [DW-1:0] g_q [NREG];
  logic [DW-1:0] g_d [NREG];
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d, bus_err_q, bus_err_d;
  logic [7:0]    tmo_q, tmo_d;

  logic [DW-1:0] xbus, alu_res, flg_new;
  logic          alu_c, cin, idle;

  assign idle = (state_q == ST_IDLE);
  assign cin  = flg_q[1];

  always_comb begin
    case (xsrc)
      5'd0:    xbus = pc_q;
      5'd1:    xbus = r_q;
      5'd2:    xbus = rdr_q;
      5'd3:    xbus = flg_q;
      5'd4:    xbus = sync2_q;
      default: xbus = '1;
    endcase
    for (int k = 0; k < NREG; k++)
      if (xsrc == 5'(16 + k)) xbus = g_q[k];
  end

  // Subtract variants compute in DW+1 bits so the top bit is the borrow.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (aluop)
      4'd0:  alu_res = xbus;
      4'd1:  {alu_c, alu_res} = {1'b0, xbus} + {1'b0, t_q};
      4'd2:  {alu_c, alu_res} = {1'b0, xbus} + {1'b0, t_q} + (DW+1)'(cin);
      4'd3:  {alu_c, alu_res} = {1'b0, xbus} - {1'b0, t_q};
      4'd4:  {alu_c, alu_res} = {1'b0, xbus} - {1'b0, t_q} - (DW+1)'(cin);
      4'd5:  alu_res = xbus & t_q;
      4'd6:  alu_res = xbus | t_q;
      4'd7:  alu_res = xbus ^ t_q;
      4'd8:  alu_res = ~xbus;
      4'd9:  begin alu_res = {xbus[DW-2:0], 1'b0}; alu_c = xbus[DW-1]; end
      4'd10: begin alu_res = {1'b0, xbus[DW-1:1]}; alu_c = xbus[0]; end
      4'd11: begin alu_res = {xbus[DW-2:0], cin};  alu_c = xbus[DW-1]; end
      4'd12: begin alu_res = {cin, xbus[DW-1:1]};  alu_c = xbus[0]; end
      4'd13: {alu_c, alu_res} = {1'b0, xbus} + (DW+1)'(1);
      4'd14: {alu_c, alu_res} = {1'b0, xbus} - (DW+1)'(1);
      default: alu_res = t_q;
    endcase
    flg_new      = '0;
    flg_new[3:1] = {alu_res[DW-1], (alu_res == '0), alu_c};
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    i_d       = i_q;
    t_d       = t_q;
    r_d       = r_q;
    mar_d     = mar_q;
    wdr_d     = wdr_q;
    rdr_d     = rdr_q;
    flg_d     = flg_q;
    oport_d   = oport_q;
    g_d       = g_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    bus_err_d = bus_err_q;
    tmo_d     = tmo_q;
    if (idle) begin
      if (pc_inc) pc_d = pc_q + 1'b1;
      case (xdst)
        5'd0:    pc_d    = xbus;
        5'd1:    i_d     = xbus;
        5'd2:    t_d     = xbus;
        5'd3:    mar_d   = xbus;
        5'd4:    wdr_d   = xbus;
        5'd5:    oport_d = xbus;
        default: ;
      endcase
      for (int k = 0; k < NREG; k++)
        if (xdst == 5'(16 + k)) g_d[k] = xbus;
      if (rwr) r_d = alu_res;
      if (fwr) flg_d = flg_new;
      if (mem_rd || mem_wr) begin
        state_d   = ST_CYC;
        mem_req_d = 1'b1;
        mem_we_d  = mem_wr;
        tmo_d     = 8'(TIMEOUT - 1);
      end
    end else begin
      if (mem.mem_ack) begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        if (!mem_we_q) rdr_d = mem.data_in;
      end else if (tmo_q == 8'd0) begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        bus_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q   <= ST_IDLE;
      pc_q      <= PC_RST;
      i_q       <= '0;
      t_q       <= '0;
      r_q       <= '0;
      mar_q     <= '0;
      wdr_q     <= '0;
      rdr_q     <= '0;
      flg_q     <= '0;
      oport_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      for (int k = 0; k < NREG; k++) g_q[k] <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      bus_err_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      i_q       <= i_d;
      t_q       <= t_d;
      r_q       <= r_d;
      mar_q     <= mar_d;
      wdr_q     <= wdr_d;
      rdr_q     <= rdr_d;
      flg_q     <= flg_d;
      oport_q   <= oport_d;
      sync1_q   <= io_in;
      sync2_q   <= sync1_q;
      g_q       <= g_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      bus_err_q <= bus_err_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    case (resad)
      8'h00:   resdt = pc_q;
      8'h01:   resdt = i_q;
      8'h02:   resdt = t_q;
      8'h03:   resdt = r_q;
      8'h04:   resdt = mar_q;
      8'h05:   resdt = mem.data_in;
      8'h06:   resdt = rdr_q;
      8'h07:   resdt = wdr_q;
      8'h08:   resdt = flg_q;
      8'h09:   resdt = xbus;
      8'h0A:   resdt = sync2_q;
      8'h0B:   resdt = DW'({busy, bus_err_q});
      default: resdt = '0;
    endcase
    for (int k = 0; k < NREG; k++)
      if (resad == 8'(16 + k)) resdt = g_q[k];
  end

  assign busy         = ~idle;
  assign bus_err      = bus_err_q;
  assign io_out       = oport_q;
  assign I            = i_q;
  assign SZCy         = flg_q[3:1];
  assign mem.adrs     = mar_q;
  assign mem.data_out = wdr_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = mem_we_q;
endmodule

// File: tb/tb_cdec_dp_gen.sv
// Directed bench: 8-bit/3-register instance for data path and memory FSM,
// 16-bit/8-register instance for width, G7 access and async reset mid-cycle.
module tb_cdec_dp_gen;
  logic        clk;
  logic        rst8_n, rst16_n;
  logic [4:0]  xsrc, xdst;
  logic [3:0]  aluop;
  logic        rwr, fwr, pc_inc, mem_rd, mem_wr;
  logic [7:0]  resad;

  logic [7:0]  io_in8, io_out8, i8, resdt8;
  logic [2:0]  szcy8;
  logic        busy8, bus_err8;
  logic [15:0] io_in16, io_out16, i16, resdt16;
  logic [2:0]  szcy16;
  logic        busy16, bus_err16;

  int n_chk = 0;
  int n_err = 0;

  cdec_dp_gen_if #(.DW(8))  m8 ();
  cdec_dp_gen_if #(.DW(16)) m16 ();

  cdec_dp_gen #(.DW(8), .NREG(3), .PC_RST(8'h40), .TIMEOUT(15)) u_dut8 (
    .clock(clk), .reset_N(rst8_n), .io_in(io_in8), .io_out(io_out8), .mem(m8),
    .xsrc(xsrc), .xdst(xdst), .aluop(aluop), .rwr(rwr), .fwr(fwr),
    .pc_inc(pc_inc), .mem_rd(mem_rd), .mem_wr(mem_wr), .I(i8), .SZCy(szcy8),
    .busy(busy8), .bus_err(bus_err8), .resad(resad), .resdt(resdt8)
  );

  cdec_dp_gen #(.DW(16), .NREG(8), .PC_RST(16'h0000), .TIMEOUT(15)) u_dut16 (
    .clock(clk), .reset_N(rst16_n), .io_in(io_in16), .io_out(io_out16), .mem(m16),
    .xsrc(xsrc), .xdst(xdst), .aluop(aluop), .rwr(rwr), .fwr(fwr),
    .pc_inc(pc_inc), .mem_rd(mem_rd), .mem_wr(mem_wr), .I(i16), .SZCy(szcy16),
    .busy(busy16), .bus_err(bus_err16), .resad(resad), .resdt(resdt16)
  );

  always #50 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic dbg8(input string tag, input logic [7:0] a, input logic [31:0] exp);
    resad = a;
    #1;
    chk(tag, 32'(resdt8), exp);
  endtask

  task automatic dbg16(input string tag, input logic [7:0] a, input logic [31:0] exp);
    resad = a;
    #1;
    chk(tag, 32'(resdt16), exp);
  endtask

  initial begin
    clk = 0; rst8_n = 0; rst16_n = 0;
    io_in8 = 0; io_in16 = 0;
    xsrc = 0; xdst = 5'd31; aluop = 0;
    rwr = 0; fwr = 0; pc_inc = 0; mem_rd = 0; mem_wr = 0; resad = 0;
    m8.mem_ack = 0; m8.data_in = 0; m16.mem_ack = 0; m16.data_in = 0;
    tick; tick;

    dbg8("rst_pc", 8'h00, 32'h40);
    chk("rst_io_out", 32'(io_out8), 32'h0);
    chk("rst_mem_req", 32'(m8.mem_req), 32'h0);
    chk("rst_busy", 32'(busy8), 32'h0);
    dbg8("rst_xbus_pc", 8'h09, 32'h40);

    rst8_n = 1; io_in8 = 8'h01;
    xsrc = 5'd5; xdst = 5'd17; tick; xdst = 5'd31;
    dbg8("g1_load", 8'h11, 32'hFF);
    dbg8("iport_1clk", 8'h0A, 32'h00);
    tick;
    dbg8("iport_2clk", 8'h0A, 32'h01);
    xsrc = 5'd4; xdst = 5'd2; tick; xdst = 5'd31;
    dbg8("t_load", 8'h02, 32'h01);
    io_in8 = 8'h12;

    xsrc = 5'd17; aluop = 4'd1; rwr = 1; fwr = 1; tick;
    dbg8("add_r", 8'h03, 32'h00);
    chk("add_szcy", 32'(szcy8), 32'b011);
    dbg8("add_flg", 8'h08, 32'h06);
    aluop = 4'd2; tick;
    dbg8("adc_r", 8'h03, 32'h01);
    chk("adc_szcy", 32'(szcy8), 32'b001);
    aluop = 4'd3; tick;
    dbg8("sub_r", 8'h03, 32'hFE);
    chk("sub_szcy", 32'(szcy8), 32'b100);
    aluop = 4'd10; tick;
    dbg8("shr_r", 8'h03, 32'h7F);
    chk("shr_szcy", 32'(szcy8), 32'b001);
    aluop = 4'd12; tick;
    dbg8("ror_r", 8'h03, 32'hFF);
    chk("ror_szcy", 32'(szcy8), 32'b101);
    rwr = 0; fwr = 0; aluop = 0;

    xsrc = 5'd4; xdst = 5'd3; tick; xdst = 5'd31;
    chk("mar_adrs", 32'(m8.adrs), 32'h12);
    io_in8 = 8'h3C;
    mem_rd = 1; tick; mem_rd = 0;
    chk("rd_req", 32'(m8.mem_req), 32'h1);
    chk("rd_we", 32'(m8.mem_we), 32'h0);
    chk("rd_busy", 32'(busy8), 32'h1);
    tick; tick; tick;
    chk("rd_req_wait", 32'(m8.mem_req), 32'h1);
    dbg8("rd_rdr_before", 8'h06, 32'h00);
    m8.mem_ack = 1; m8.data_in = 8'hA5; tick; m8.mem_ack = 0;
    chk("rd_req_done", 32'(m8.mem_req), 32'h0);
    chk("rd_busy_done", 32'(busy8), 32'h0);
    dbg8("rd_rdr", 8'h06, 32'hA5);

    xsrc = 5'd4; xdst = 5'd4; tick; xdst = 5'd31;
    chk("wdr_data_out", 32'(m8.data_out), 32'h3C);
    io_in8 = 8'h77;
    mem_wr = 1; tick; mem_wr = 0;
    chk("wr_req", 32'(m8.mem_req), 32'h1);
    chk("wr_we", 32'(m8.mem_we), 32'h1);
    xsrc = 5'd5; xdst = 5'd5; pc_inc = 1;
    repeat (14) tick;
    chk("wr_req_cyc14", 32'(m8.mem_req), 32'h1);
    chk("wr_err_cyc14", 32'(bus_err8), 32'h0);
    tick; xdst = 5'd31; pc_inc = 0;
    chk("tmo_req", 32'(m8.mem_req), 32'h0);
    chk("tmo_bus_err", 32'(bus_err8), 32'h1);
    dbg8("tmo_status", 8'h0B, 32'h01);
    chk("busy_io_out", 32'(io_out8), 32'h00);
    dbg8("busy_pc", 8'h00, 32'h40);
    dbg8("tmo_rdr", 8'h06, 32'hA5);

    xsrc = 5'd5; xdst = 5'd0; tick; xdst = 5'd31;
    dbg8("pc_ff", 8'h00, 32'hFF);
    pc_inc = 1; tick;
    dbg8("pc_wrap", 8'h00, 32'h00);
    xsrc = 5'd4; xdst = 5'd0; tick;
    dbg8("pc_xdst_prio", 8'h00, 32'h77);
    xdst = 5'd5; pc_inc = 0; tick; xdst = 5'd31;
    chk("oport", 32'(io_out8), 32'h77);
    chk("bus_err_sticky", 32'(bus_err8), 32'h1);

    rst16_n = 1; io_in16 = 16'h1234; tick;
    dbg16("w16_iport_1clk", 8'h0A, 32'h0000);
    tick;
    dbg16("w16_iport_2clk", 8'h0A, 32'h1234);
    xsrc = 5'd4; xdst = 5'd23; tick; xdst = 5'd31;
    dbg16("w16_g7", 8'h17, 32'h1234);
    xsrc = 5'd23;
    dbg16("w16_xbus_g7", 8'h09, 32'h1234);
    mem_rd = 1; tick; mem_rd = 0;
    chk("w16_req", 32'(m16.mem_req), 32'h1);
    tick;
    chk("w16_req_hold", 32'(m16.mem_req), 32'h1);
    #10 rst16_n = 0;
    #1;
    chk("w16_rst_req", 32'(m16.mem_req), 32'h0);
    chk("w16_rst_busy", 32'(busy16), 32'h0);
    dbg16("w16_rst_g7", 8'h17, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cdec_dp_gen.md
Name: cdec_dp_gen

Overview:
Parametrised next-generation CDEC data path. Generalises the 8-bit, fixed-register data path to configurable data width and general-register count. Adds a handshaked memory bus FSM with timeout, a PC auto-increment, and a two-flop input-port synchroniser. Sits between the CDEC control unit (ctrl in, I/SZCy/busy out), external memory, the I/O pins and the PC debug monitor.

Parameters:
DW, 8, data/address width in bits (8..16)
NREG, 3, number of general registers G0..G(NREG-1) (1..16); G0/G1/G2 take the roles of A/B/C
PC_RST, 0, PC value after reset
TIMEOUT, 15, max cycles waiting for mem_ack before bus error (1..255)

Ports:
clock  in  1  system clock, all state on rising edge
reset_N  in  1  asynchronous active-low reset
io_in  in  DW  input port pins (asynchronous)
io_out  out  DW  output port register
adrs  out  DW  memory address (= MAR)
data_out  out  DW  memory write data (= WDR)
data_in  in  DW  memory read data
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  1 = write cycle, valid while mem_req
mem_ack  in  1  memory acknowledge, sampled while mem_req=1
xsrc  in  5  XBUS source select
xdst  in  5  XBUS destination select
aluop  in  4  ALU operation
rwr  in  1  load R with ALU result
fwr  in  1  load FLG with ALU flags
pc_inc  in  1  PC <= PC+1
mem_rd  in  1  start read cycle (one-cycle strobe)
mem_wr  in  1  start write cycle (one-cycle strobe)
I  out  DW  instruction register
SZCy  out  3  {S,Z,Cy} = FLG[3:1]
busy  out  1  memory cycle in progress
bus_err  out  1  sticky timeout flag
resad  in  8  debug resource address
resdt  out  DW  debug resource data

Behaviour:
- Reset (async, reset_N=0): PC=PC_RST; I,T,R,MAR,WDR,RDR,FLG,OPORT,G* =0; sync stages=0; FSM=IDLE; mem_req=0, mem_we=0, busy=0, bus_err=0. Reset mid memory cycle drops mem_req immediately.
- XBUS (combinational) xsrc: 0 PC, 1 R, 2 RDR, 3 FLG, 4 IPORT, 5 all-ones, 16+k Gk (k<NREG); any other code all-ones.
- xdst (registered, one cycle): 0 PC, 1 I, 2 T, 3 MAR, 4 WDR, 5 OPORT, 16+k Gk; other codes no write.
- PC: xdst=0 has priority over pc_inc; pc_inc wraps 2^DW-1 -> 0.
- ALU on X=XBUS, Y=T, cin=FLG[1]; ops: 0 X, 1 X+Y, 2 X+Y+cin, 3 X-Y, 4 X-Y-cin, 5 AND, 6 OR, 7 XOR, 8 ~X, 9 SHL (C=msb out), 10 SHR (C=lsb out), 11 ROL through C, 12 ROR through C, 13 X+1, 14 X-1, 15 Y. Subtract C = borrow. Logic ops/pass C=0. S=msb, Z=(result==0). FLG <= {0..,S,Z,C,0}.
- IPORT: io_in through two flops; XBUS sees value 2 cycles after pin change.
- Memory FSM: IDLE, CYC. In IDLE, mem_rd or mem_wr -> CYC, mem_req=1, mem_we=mem_wr (both set: write wins). In CYC: mem_ack=1 -> IDLE, read latches data_in into RDR same edge. No ack for TIMEOUT cycles -> IDLE, bus_err=1, RDR unchanged. busy=(state==CYC); min cycle 2 clocks (req edge, ack edge).
- While busy=1: xdst, rwr, fwr, pc_inc, mem_rd, mem_wr ignored (no state change). bus_err cleared only by reset.
- Debug resdt (pure mux, no tristates): 00 PC, 01 I, 02 T, 03 R, 04 MAR, 05 data_in, 06 RDR, 07 WDR, 08 FLG, 09 XBUS, 0A IPORT, 0B {busy,bus_err} zero-extended, 10+k Gk; else 0.

Test Plan:
- Reset with PC_RST=8'h40 -> PC=40, io_out=0, mem_req=0, busy=0; xsrc=0 gives XBUS=40.
- G1=8'hFF, T=8'h01, aluop=1, rwr=fwr=1 -> R=00, SZCy=3'b011; aluop=2 next cycle -> R=01.
- MAR=12, mem_rd pulse, mem_ack after 3 cycles with data_in=A5 -> mem_req high 4 cycles, RDR=A5, busy falls with ack.
- WDR=3C, mem_wr, never ack, TIMEOUT=15 -> mem_req drops after 15 cycles, bus_err=1, resad=0B reads 01; xdst writes during busy ignored.
- PC=FF, pc_inc=1 -> PC=00; xdst=0 with XBUS=77 and pc_inc same cycle -> PC=77.
- DW=16, NREG=8: io_in=1234 -> IPORT=1234 after 2 clocks; xdst=23 loads G7, resad=17 reads it; async reset mid mem cycle clears mem_req.
